sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_sram_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port arbiter in front of an asynchronous 16-bit SRAM.
//
// Each port issues word-sized reads or byte-masked writes. A granted access
// runs IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> DONE (1 cycle, ack pulse) and
// then returns to IDLE. The IDLE cycle between accesses gives the data bus
// time to turn around.
//
// All SRAM strobes, ack pulses and the data-bus enable come straight from
// flops. They are computed from the next state, so they do not glitch when
// the state register changes.
//
// Build option:
//   SRAM_ARB_FIXED_PRIORITY_EN  when defined, port 0 always wins a tie and
//                               the round-robin pointer is not built.
//                               When undefined, ties alternate round-robin.

module sram_arbiter #(
  parameter int WAIT_CYCLES = 1   // extra strobe cycles beyond the first, 0..7
) (
  input  logic        clk,
  input  logic        rst,         // synchronous, active-low

  input  logic        req0,
  input  logic        we0,
  input  logic [1:0]  be0,
  input  logic [17:0] addr0,
  input  logic [15:0] wdata0,
  output logic        ack0,

  input  logic        req1,
  input  logic        we1,
  input  logic [1:0]  be1,
  input  logic [17:0] addr1,
  input  logic [15:0] wdata1,
  output logic        ack1,

  output logic [15:0] rdata,

  output logic [17:0] sram_adr,
  output logic [15:0] sram_dq_o,
  input  logic [15:0] sram_dq_i,
  output logic        sram_dq_oe,
  output logic        sram_cs_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_lb_n,
  output logic        sram_ub_n
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  // Value of wait_cnt in the final ACCESS cycle.
  localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [2:0]  wait_cnt;
  logic [2:0]  wait_cnt_nxt;

  // Fields of the granted request, held for the whole access.
  logic        gnt;          // 0 = port 0, 1 = port 1
  logic        lat_we;
  logic [1:0]  lat_be;

  // Arbitration results for the current IDLE cycle.
  logic        grant_en;
  logic        grant_port;

  // Field values after the coming edge (new grant or held values).
  logic        gnt_nxt;
  logic        we_nxt;
  logic [1:0]  be_nxt;
  logic        in_access_nxt;
  logic        in_done_nxt;
  logic        last_access;

`ifndef SRAM_ARB_FIXED_PRIORITY_EN
  logic        last_gnt;     // port granted most recently
`endif

  // Choose which port to grant when the FSM is idle.
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // first; otherwise a path that skips the assignment infers a latch.
    grant_port = 1'b0;
`ifdef SRAM_ARB_FIXED_PRIORITY_EN
    grant_port = ~req0;
`else
    if (req0 && req1) begin
      grant_port = ~last_gnt;
    end else begin
      grant_port = req1;
    end
`endif
  end

  assign grant_en    = (state == IDLE) && (req0 || req1);
  assign last_access = (state == ACCESS) && (wait_cnt == WAIT_LAST);

  // Select the field values that will be held during the next cycle.
  always_comb begin
    gnt_nxt = gnt;
    we_nxt  = lat_we;
    be_nxt  = lat_be;
    if (grant_en) begin
      gnt_nxt = grant_port;
      we_nxt  = grant_port ? we1 : we0;
      be_nxt  = grant_port ? be1 : be0;
    end
  end

  // Next-state logic and ACCESS length counter.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    unique case (state)
      IDLE: begin
        if (grant_en) begin
          state_nxt    = ACCESS;
          wait_cnt_nxt = 3'd0;
        end
      end
      ACCESS: begin
        if (wait_cnt == WAIT_LAST) begin
          state_nxt = DONE;
        end else begin
          wait_cnt_nxt = wait_cnt + 3'd1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign in_access_nxt = (state_nxt == ACCESS);
  assign in_done_nxt   = (state_nxt == DONE);

  // State register. A reset at any point abandons the access in flight.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so that every flop
    // samples pre-edge values, regardless of the order of the statements.
    if (!rst) begin
      state    <= IDLE;
      wait_cnt <= 3'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Capture the granted request. The captured address and write data drive
  // the SRAM directly, so they stay stable through DONE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      gnt       <= 1'b0;
      lat_we    <= 1'b0;
      lat_be    <= 2'b00;
      sram_adr  <= '0;
      sram_dq_o <= '0;
    end else if (grant_en) begin
      gnt       <= grant_port;
      lat_we    <= grant_port ? we1    : we0;
      lat_be    <= grant_port ? be1    : be0;
      sram_adr  <= grant_port ? addr1  : addr0;
      sram_dq_o <= grant_port ? wdata1 : wdata0;
    end
  end

`ifndef SRAM_ARB_FIXED_PRIORITY_EN
  // Round-robin pointer. Its reset value makes port 0 win the first tie.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_gnt <= 1'b1;
    end else if (grant_en) begin
      last_gnt <= grant_port;
    end
  end
`endif

  // Registered SRAM strobes and bus enable. Write data stays driven through
  // DONE to meet the SRAM's data hold time after we_n rises.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sram_cs_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_lb_n  <= 1'b1;
      sram_ub_n  <= 1'b1;
      sram_dq_oe <= 1'b0;
    end else begin
      sram_cs_n  <= ~in_access_nxt;
      sram_oe_n  <= ~(in_access_nxt && !we_nxt);
      sram_we_n  <= ~(in_access_nxt && we_nxt);
      sram_lb_n  <= ~(in_access_nxt && be_nxt[0]);
      sram_ub_n  <= ~(in_access_nxt && be_nxt[1]);
      sram_dq_oe <= (in_access_nxt || in_done_nxt) && we_nxt;
    end
  end

  // One-cycle completion pulse to the granted port, issued during DONE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
    end else begin
      ack0 <= in_done_nxt && !gnt_nxt;
      ack1 <= in_done_nxt &&  gnt_nxt;
    end
  end

  // Read data register: loaded on the edge that ends ACCESS, held otherwise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata <= '0;
    end else if (last_access && !lat_we) begin
      rdata <= sram_dq_i;
    end
  end

  // Sanity properties on the completion handshake.
  a_ack_exclusive : assert property (@(posedge clk) disable iff (!rst)
    !(ack0 && ack1));
  a_state_legal : assert property (@(posedge clk) disable iff (!rst)
    state != 2'd3);

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: scoreboard bench for sram_arbiter.
// Instance 0 has WAIT_CYCLES=1, instance 1 has 0 and instance 2 has 7.
// Each instance is paired with a behavioural SRAM model.
`timescale 1ns/1ps

module tb_sram_arbiter;

  localparam int N_DUT = 3;
`ifdef SRAM_ARB_FIXED_PRIORITY_EN
  localparam int P0_N = 6;
`else
  localparam int P0_N = 3;
`endif

  typedef struct {
    int          port;
    logic        we;
    logic [1:0]  be;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic [15:0] rexp;
    int          issue_cyc;
    bit          chk_lat;
    bit          chk_gap;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  logic        req0   [N_DUT];
  logic        we0    [N_DUT];
  logic [1:0]  be0    [N_DUT];
  logic [17:0] addr0  [N_DUT];
  logic [15:0] wdata0 [N_DUT];
  logic        ack0   [N_DUT];
  logic        req1   [N_DUT];
  logic        we1    [N_DUT];
  logic [1:0]  be1    [N_DUT];
  logic [17:0] addr1  [N_DUT];
  logic [15:0] wdata1 [N_DUT];
  logic        ack1   [N_DUT];
  logic [15:0] rdata  [N_DUT];
  logic [17:0] sram_adr [N_DUT];
  logic [15:0] dq_o   [N_DUT];
  logic [15:0] dq_i   [N_DUT];
  logic        dq_oe  [N_DUT];
  logic        cs_n   [N_DUT];
  logic        oe_n   [N_DUT];
  logic        we_n   [N_DUT];
  logic        lb_n   [N_DUT];
  logic        ub_n   [N_DUT];

  int   n_checks = 0;
  int   n_errors = 0;
  txn_t sb [2*N_DUT][$];          // expected completions per instance and port
  int   gseq [$];                 // order of completions on instance 0
  logic [15:0] shadow [int];      // expected memory contents

  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    localparam int W = (g == 0) ? 1 : (g == 1) ? 0 : 7;

    sram_arbiter #(.WAIT_CYCLES(W)) u_dut (
      .clk(clk), .rst(rst),
      .req0(req0[g]), .we0(we0[g]), .be0(be0[g]), .addr0(addr0[g]),
      .wdata0(wdata0[g]), .ack0(ack0[g]),
      .req1(req1[g]), .we1(we1[g]), .be1(be1[g]), .addr1(addr1[g]),
      .wdata1(wdata1[g]), .ack1(ack1[g]),
      .rdata(rdata[g]),
      .sram_adr(sram_adr[g]), .sram_dq_o(dq_o[g]), .sram_dq_i(dq_i[g]),
      .sram_dq_oe(dq_oe[g]), .sram_cs_n(cs_n[g]), .sram_oe_n(oe_n[g]),
      .sram_we_n(we_n[g]), .sram_lb_n(lb_n[g]), .sram_ub_n(ub_n[g])
    );

    // SRAM model: byte-masked write on clock edges with cs_n/we_n low.
    // Read data is presented mid-cycle while cs_n/oe_n are low.
    logic [15:0] mem [int];
    initial forever begin
      @(posedge clk);
      if (!cs_n[g] && !we_n[g]) begin
        logic [15:0] w;
        w = mem.exists(int'(sram_adr[g])) ? mem[int'(sram_adr[g])] : 16'h0000;
        if (!lb_n[g]) w[7:0]  = dq_o[g][7:0];
        if (!ub_n[g]) w[15:8] = dq_o[g][15:8];
        mem[int'(sram_adr[g])] = w;
      end
    end
    initial forever begin
      @(negedge clk);
      if (!cs_n[g] && !oe_n[g]) begin
        dq_i[g] = mem.exists(int'(sram_adr[g])) ? mem[int'(sram_adr[g])] : 16'h0000;
      end else begin
        dq_i[g] = 16'hBAD0;
      end
    end

    // Monitor: accumulate strobe activity per access and score it at ack.
    initial begin
      int          n_cs, n_we, n_oe, n_dqoe, prev_ack, idx;
      logic [17:0] s_adr;
      logic [1:0]  s_bn, bn_exp;
      logic [15:0] s_dqo, st_act, st_exp;
      txn_t        t;
      n_cs = 0; n_we = 0; n_oe = 0; n_dqoe = 0; prev_ack = -1000;
      s_adr = '0; s_bn = '0; s_dqo = '0;
      forever begin
        @(negedge clk);
        if (!rst) begin
          n_cs = 0; n_we = 0; n_oe = 0; n_dqoe = 0; prev_ack = -1000;
          continue;
        end
        if (!cs_n[g]) begin
          n_cs++;
          s_adr = sram_adr[g];
          s_bn  = {ub_n[g], lb_n[g]};
        end
        if (!we_n[g]) n_we++;
        if (!oe_n[g]) n_oe++;
        if (dq_oe[g]) begin
          n_dqoe++;
          s_dqo = dq_o[g];
        end
        if (ack0[g] || ack1[g]) begin
          check("ack_exclusive", {31'b0, ack0[g] & ack1[g]}, 32'd0);
          idx = 2 * g + (ack1[g] ? 1 : 0);
          check("ack_pending", {31'b0, sb[idx].size() != 0}, 32'd1);
          if (sb[idx].size() != 0) begin
            t = sb[idx].pop_front();
            if (g == 0) gseq.push_back(t.port);
            bn_exp = ~t.be;
            st_act = {4'(n_cs), 4'(n_we), 4'(n_oe), 4'(n_dqoe)};
            st_exp = {4'(W + 1), 4'(t.we ? W + 1 : 0), 4'(t.we ? 0 : W + 1),
                      4'(t.we ? W + 2 : 0)};
            check("sram_adr", 32'(s_adr), 32'(t.addr));
            check("byte_strobes", 32'(s_bn), 32'(bn_exp));
            check("strobe_cycles", 32'(st_act), 32'(st_exp));
            if (t.we) check("dq_o_hold", 32'(s_dqo), 32'(t.wdata));
            else      check("rdata", 32'(rdata[g]), 32'(t.rexp));
            if (t.chk_lat) check("ack_latency", cyc - t.issue_cyc, W + 2);
            if (t.chk_gap) check("ack_spacing", cyc - prev_ack, W + 3);
          end
          prev_ack = cyc;
          n_cs = 0; n_we = 0; n_oe = 0; n_dqoe = 0;
        end
      end
    end
  end

  task automatic drive(int i, int p, logic r, logic w, logic [1:0] b,
                       logic [17:0] a, logic [15:0] d);
    if (p == 0) begin
      req0[i] = r; we0[i] = w; be0[i] = b; addr0[i] = a; wdata0[i] = d;
    end else begin
      req1[i] = r; we1[i] = w; be1[i] = b; addr1[i] = a; wdata1[i] = d;
    end
  endtask

  // Present one request (called just after a rising edge), push its expected
  // result and wait, bounded, for its ack. keep leaves req high so the next
  // call forms a back-to-back request.
  task automatic issue(int i, int p, logic w, logic [1:0] b, logic [17:0] a,
                       logic [15:0] d, bit lat, bit gap, bit keep);
    txn_t        t;
    int          key;
    logic [15:0] old;
    logic        got;
    key = i * (1 << 20) + int'(a);
    old = shadow.exists(key) ? shadow[key] : 16'h0000;
    t.port = p; t.we = w; t.be = b; t.addr = a; t.wdata = d; t.rexp = old;
    t.issue_cyc = cyc; t.chk_lat = lat; t.chk_gap = gap;
    if (w) shadow[key] = {b[1] ? d[15:8] : old[15:8], b[0] ? d[7:0] : old[7:0]};
    sb[2 * i + p].push_back(t);
    drive(i, p, 1'b1, w, b, a, d);
    got = 1'b0;
    for (int n = 0; n < 400 && !got; n++) begin
      @(negedge clk);
      got = (p == 0) ? ack0[i] : ack1[i];
    end
    check("ack_seen", {31'b0, got}, 32'd1);
    @(posedge clk);
    #1;
    if (!keep) drive(i, p, 1'b0, 1'b0, 2'b00, '0, '0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  function automatic logic [23:0] idle_vec(int i);
    return {cs_n[i], oe_n[i], we_n[i], lb_n[i], ub_n[i], dq_oe[i], ack0[i],
            ack1[i], rdata[i]};
  endfunction

  initial begin
    int base;
    int first;
    int exp_seq [6];

    for (int i = 0; i < N_DUT; i++) begin
      drive(i, 0, 1'b0, 1'b0, 2'b00, '0, '0);
      drive(i, 1, 1'b0, 1'b0, 2'b00, '0, '0);
    end

    // Reset values after the first edges with rst low.
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N_DUT; i++) check("reset_state", 32'(idle_vec(i)), 32'hF8_0000);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Write, then read back through the other port.
    issue(0, 0, 1'b1, 2'b11, 18'h00012, 16'hA5C3, 1, 0, 0);
    issue(0, 1, 1'b0, 2'b11, 18'h00012, 16'h0000, 1, 0, 0);

    // Byte-enable merge, and a be=00 write that changes nothing.
    issue(0, 0, 1'b1, 2'b11, 18'h00034, 16'hFFFF, 1, 0, 0);
    issue(0, 1, 1'b1, 2'b01, 18'h00034, 16'h1234, 1, 0, 0);
    issue(0, 0, 1'b0, 2'b11, 18'h00034, 16'h0000, 1, 0, 0);
    issue(0, 1, 1'b1, 2'b00, 18'h00034, 16'hAAAA, 1, 0, 0);
    issue(0, 0, 1'b0, 2'b11, 18'h00034, 16'h0000, 1, 0, 0);

    // Both ports held high continuously.
    do_reset();
    gseq.delete();
    fork
      begin
        for (int k = 0; k < P0_N; k++)
          issue(0, 0, 1'b0, 2'b11, 18'h00012, 16'h0000, 0, k > 0, k < P0_N - 1);
      end
      begin
        for (int k = 0; k < 3; k++)
          issue(0, 1, 1'b0, 2'b11, 18'h00034, 16'h0000, 0, 1, k < 2);
      end
    join
`ifdef SRAM_ARB_FIXED_PRIORITY_EN
    exp_seq = '{0, 0, 0, 0, 0, 0};
`else
    exp_seq = '{0, 1, 0, 1, 0, 1};
`endif
    for (int k = 0; k < 6; k++)
      check("grant_order", (gseq.size() > k) ? gseq[k] : -1, exp_seq[k]);

    // Reset during the second ACCESS cycle of a port-0 write.
    drive(0, 0, 1'b1, 1'b1, 2'b11, 18'h000F0, 16'h5555);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(0, 0, 1'b0, 1'b0, 2'b00, '0, '0);
    @(posedge clk);
    @(negedge clk);
    check("abort_state", 32'(idle_vec(0)), 32'hF8_0000);
    @(negedge clk);
    check("abort_hold", 32'(idle_vec(0)), 32'hF8_0000);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_ack", {30'b0, ack0[0], ack1[0]}, 32'd0);
    @(posedge clk);
    #1;
    base = gseq.size();
    fork
      issue(0, 0, 1'b0, 2'b11, 18'h00012, 16'h0000, 0, 0, 0);
      issue(0, 1, 1'b0, 2'b11, 18'h00034, 16'h0000, 0, 0, 0);
    join
    first = (gseq.size() > base) ? gseq[base] : -1;
    check("post_reset_grant", first, 0);

    // Back-to-back reads with the shortest and longest strobe settings.
    for (int i = 1; i < N_DUT; i++) begin
      issue(i, 0, 1'b1, 2'b11, 18'h00040, 16'h0F0F + 16'(i), 1, 0, 0);
      issue(i, 1, 1'b0, 2'b11, 18'h00040, 16'h0000, 1, 0, 1);
      issue(i, 1, 1'b0, 2'b11, 18'h00040, 16'h0000, 1, 1, 0);
    end

    repeat (3) @(posedge clk);
    for (int q = 0; q < 2 * N_DUT; q++) check("sb_drained", sb[q].size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
